cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder, one SEG = WIDTH/STAGES bit segment resolved per stage.
// Latency: operands accepted at edge N appear with out_valid=1 after edge N+STAGES-1.
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Optional feature macro CLA_PIPE_SUB_EN: adds 'sub' (invert b at accept) and 'ovf' (signed overflow) ports.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLK    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef CLA_PIPE_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / BLK;

  if (WIDTH % STAGES != 0) begin : g_chk_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of STAGES");
  end
  if (SEG % BLK != 0) begin : g_chk_blk
    $fatal(1, "cla_pipe_adder: WIDTH/STAGES must be a multiple of BLK");
  end

  // One segment add: returns {carry_out, sum}. Group carries are formed as
  // flat sum-of-products over group G/P terms, so no carry ripples from one
  // group into the next; bit carries inside a group derive from its group carry.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gg;
    logic [NG-1:0]  gp;
    logic [NG:0]    gc;
    logic           t;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        t = g[j*BLK+i];
        for (int m = i + 1; m < BLK; m++) t = t & p[j*BLK+m];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[j*BLK+i];
      end
    end
    for (int j = 0; j <= NG; j++) begin
      t = cin;
      for (int m = 0; m < j; m++) t = t & gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < BLK; i++) begin
        t = gc[j];
        for (int m = 0; m < i; m++) t = t & p[j*BLK+m];
        c[j*BLK+i] = t;
        for (int k = 0; k < i; k++) begin
          t = g[j*BLK+k];
          for (int m = k + 1; m < i; m++) t = t & p[j*BLK+m];
          c[j*BLK+i] = c[j*BLK+i] | t;
        end
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_in;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

`ifdef CLA_PIPE_SUB_EN
  assign w_b_in = b ^ {WIDTH{sub}};
`else
  assign w_b_in = b;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Bits finished once this stage has registered, and operand bits still pending.
    localparam int DONE = SEG * (k + 1);
    localparam int REM  = WIDTH - DONE;

    logic            w_vld_in;
    logic            w_cin;
    logic [SEG-1:0]  w_x;
    logic [SEG-1:0]  w_y;
    logic [SEG:0]    w_res;
    logic [DONE-1:0] w_sum_nxt;
    logic            r_vld;
    logic            r_c;
    logic [DONE-1:0] r_sum;

    if (k == 0) begin : g_first
      assign w_vld_in  = in_valid;
      assign w_cin     = ci;
      assign w_x       = a[SEG-1:0];
      assign w_y       = w_b_in[SEG-1:0];
      assign w_sum_nxt = w_res[SEG-1:0];
    end else begin : g_next
      assign w_vld_in  = g_stg[k-1].r_vld;
      assign w_cin     = g_stg[k-1].r_c;
      assign w_x       = g_stg[k-1].g_op.r_a[SEG-1:0];
      assign w_y       = g_stg[k-1].g_op.r_b[SEG-1:0];
      assign w_sum_nxt = {w_res[SEG-1:0], g_stg[k-1].r_sum};
    end

    assign w_res = seg_add(w_x, w_y, w_cin);

    // Stage valid moves on every advance; data only loads behind a valid so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_in;
        if (w_vld_in) begin
          r_c   <= w_res[SEG];
          r_sum <= w_sum_nxt;
        end
      end
    end

    if (REM > 0) begin : g_op
      logic [REM-1:0] w_a_nxt;
      logic [REM-1:0] w_b_nxt;
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;

      if (k == 0) begin : g_src_in
        assign w_a_nxt = a[WIDTH-1:SEG];
        assign w_b_nxt = w_b_in[WIDTH-1:SEG];
      end else begin : g_src_prev
        assign w_a_nxt = g_stg[k-1].g_op.r_a[REM+SEG-1:SEG];
        assign w_b_nxt = g_stg[k-1].g_op.r_b[REM+SEG-1:SEG];
      end

      // Skew registers carry the not-yet-added operand slices down the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vld_in) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_vld;
  assign s         = g_stg[STAGES-1].r_sum;
  assign co        = g_stg[STAGES-1].r_c;

`ifdef CLA_PIPE_SUB_EN
  logic w_ovf_nxt;
  logic r_ovf;

  // Carry into the MSB is recovered as sum ^ a ^ b at the top bit.
  assign w_ovf_nxt = g_stg[STAGES-1].w_res[SEG] ^
                     (g_stg[STAGES-1].w_res[SEG-1] ^ g_stg[STAGES-1].w_x[SEG-1] ^
                      g_stg[STAGES-1].w_y[SEG-1]);

  // Overflow flag is registered with the last stage so it stays aligned with s/co.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && g_stg[STAGES-1].w_vld_in) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
